// File: rtl/riscv_pkg.sv
// Shared fetch-side types: FSM state encoding, PC step and the buffered {pc, instr} entry.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush beats push/pop and the head is a register
// that holds its last value while the FIFO is empty.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  fetch_entry_t                   push_data_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output fetch_entry_t                   head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     head_q;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, rd_next;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok = push_i && !flush_i;
    pop_ok  = pop_i && !flush_i && (count_q != '0);
    rd_next = rd_ptr_q + PTR_W'(1);
  end

  // Storage array needs no reset: only slots below count are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_next;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // Head follows the entry that will be at rd_ptr after this edge.
      if (push_ok && ((count_q == '0) || (pop_ok && (count_q == CNT_W'(1)))))
        head_q <= push_data_i;
      else if (pop_ok && (count_q > CNT_W'(1)))
        head_q <= mem_q[rd_next];
    end
  end

  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps one imem request outstanding,
// buffers responses for decode and flushes everything on a redirect.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     WIDTH      = XLEN,
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head, push_entry;
  logic             req_fire, push, pop;

  always_comb begin
    imem_req_valid = !rst && (state_q == FETCH) && !redirect_valid
                     && (count < CNT_W'(FIFO_DEPTH));
    req_fire       = imem_req_valid && imem_req_ready;
    instr_valid    = (count != '0) && !redirect_valid;
    pop            = instr_valid && instr_ready;
    push           = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
    push_entry     = '{pc: XLEN'(req_pc_q), instr: XLEN'(imem_rsp_data)};
  end

  // Next-state: redirect overrides the PC in every state; WAIT without a response drains.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      FETCH: begin
        if (req_fire) begin
          state_d    = WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + WIDTH'(PC_INC);
        end
      end
      WAIT: begin
        if (imem_rsp_valid)      state_d = FETCH;
        else if (redirect_valid) state_d = DRAIN;
      end
      DRAIN: begin
        if (imem_rsp_valid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (redirect_valid) fetch_pc_d = redirect_pc & ~WIDTH'(3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC & ~WIDTH'(3);
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .count_o     (count),
    .head_o      (head)
  );

  assign imem_req_addr = fetch_pc_q;
  assign instr         = WIDTH'(head.instr);
  assign instr_pc      = WIDTH'(head.pc);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run scored against a
// program-order model (sequential PCs, restarted at every redirect target).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;

  logic        w_req_valid, w_ready = 1'b0;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_instr_valid;
  logic [31:0] w_instr, w_instr_pc;

  int tests = 0;
  int fails = 0;

  // Memory model state
  int          lat = 1;
  bit          mpend = 0, acc = 0;
  logic [31:0] mp_addr, acc_addr;
  int          mcd;

  always #5 clk = ~clk;

  fetch_unit #(.WIDTH(32), .FIFO_DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  fetch_unit #(.WIDTH(32), .FIFO_DEPTH(2), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(w_instr_valid), .instr_ready(1'b0), .instr(w_instr), .instr_pc(w_instr_pc)
  );

  function automatic logic [31:0] mword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Accept requests at the edge; flag a second request while one is still outstanding.
  always @(posedge clk) begin
    if (imem_req_valid && imem_req_ready) begin
      tests++;
      if (mpend) begin
        fails++;
        $display("FAIL outstanding: request to %h while %h still pending", imem_req_addr, mp_addr);
      end
      acc = 1;
      acc_addr = imem_req_addr;
    end
  end

  // Respond lat cycles after acceptance.
  always @(negedge clk) begin
    if (acc) begin
      mpend = 1; mp_addr = acc_addr; mcd = lat - 1; acc = 0;
    end
    imem_rsp_valid = 1'b0;
    if (mpend) begin
      if (mcd == 0) begin
        imem_rsp_valid = 1'b1; imem_rsp_data = mword(mp_addr); mpend = 0;
      end else mcd--;
    end
  end

  task automatic do_reset(input bit clr);
    @(negedge clk);
    rst = 1; imem_req_ready = 0; instr_ready = 0; redirect_valid = 0; redirect_pc = '0;
    w_ready = 0; w_rsp_valid = 0; lat = 1;
    if (clr) begin mpend = 0; acc = 0; end
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valids: req_valid=%b instr_valid=%b, want 0/0", imem_req_valid, instr_valid);
    end
    tests++;
    if (instr !== 32'h0 || instr_pc !== 32'h0) begin
      fails++; $display("FAIL reset_outputs: instr=%h instr_pc=%h, want 0/0", instr, instr_pc);
    end
  endtask

  task automatic test_stream();
    int npop = 0, last = -1;
    do_reset(1);
    imem_req_ready = 1; instr_ready = 1;
    for (int c = 0; c < 40 && npop < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (instr_valid && instr_ready) begin
        tests++;
        if (instr_pc !== 32'(npop * 4) || instr !== mword(32'(npop * 4))) begin
          fails++; $display("FAIL stream_data: pc=%h instr=%h, want pc=%h instr=%h",
                            instr_pc, instr, 32'(npop * 4), mword(32'(npop * 4)));
        end
        tests++;
        if ((last < 0 && c != 2) || (last >= 0 && c - last != 2)) begin
          fails++; $display("FAIL stream_timing: pop %0d at cycle %0d (prev %0d), want every 2 from cycle 2", npop, c, last);
        end
        last = c; npop++;
      end
    end
    tests++;
    if (npop != 4) begin fails++; $display("FAIL stream_count: %0d pops, want 4", npop); end
  endtask

  task automatic test_stall();
    int nreq = 0; bit bad = 0;
    do_reset(1);
    imem_req_ready = 1; instr_ready = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (imem_req_valid && imem_req_ready) nreq++;
      if (instr_valid && (instr_pc !== 32'h0 || instr !== mword(32'h0))) bad = 1;
    end
    tests++;
    if (nreq != 2) begin fails++; $display("FAIL stall_reqs: %0d requests, want 2", nreq); end
    tests++;
    if (bad || instr_valid !== 1'b1) begin
      fails++; $display("FAIL stall_hold: instr_valid=%b pc=%h unstable=%b, want 1/0 held", instr_valid, instr_pc, bad);
    end
    @(negedge clk); instr_ready = 1; #1;
    tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_req_valid !== 1'b0) begin
      fails++; $display("FAIL stall_release0: valid=%b pc=%h req_valid=%b, want 1/0/0", instr_valid, instr_pc, imem_req_valid);
    end
    @(negedge clk); #1;
    tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || instr !== mword(32'h4)) begin
      fails++; $display("FAIL stall_release4: valid=%b pc=%h instr=%h, want 1/4/%h", instr_valid, instr_pc, instr, mword(32'h4));
    end
    tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
      fails++; $display("FAIL stall_resume: req_valid=%b addr=%h, want 1/8", imem_req_valid, imem_req_addr);
    end
    instr_ready = 0;
  endtask

  task automatic test_redirect_wait();
    bit found = 0;
    int rsp_c = -1, req_c = -1, pop_c = -1;
    logic [31:0] req_a = '0, pop_pc = '0, pop_i = '0;
    do_reset(1);
    imem_req_ready = 1; instr_ready = 1;
    for (int c = 0; c < 30 && !found; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h8) begin lat = 4; found = 1; end
    end
    tests++;
    if (!found) begin fails++; $display("FAIL rdw_setup: request for 0x8 not seen"); end
    @(negedge clk); redirect_valid = 1; redirect_pc = 32'h100; #1;
    lat = 1;
    tests++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      fails++; $display("FAIL rdw_gate: instr_valid=%b req_valid=%b, want 0/0", instr_valid, imem_req_valid);
    end
    for (int c = 0; c < 30 && pop_c < 0; c++) begin
      @(negedge clk); redirect_valid = 0; #1;
      if (imem_rsp_valid && rsp_c < 0) rsp_c = c;
      if (imem_req_valid && imem_req_ready && req_c < 0) begin req_c = c; req_a = imem_req_addr; end
      if (instr_valid && instr_ready) begin pop_c = c; pop_pc = instr_pc; pop_i = instr; end
    end
    tests++;
    if (rsp_c != 2 || req_c <= rsp_c) begin
      fails++; $display("FAIL rdw_drain: stale rsp cycle %0d, first req cycle %0d, want 2 and later", rsp_c, req_c);
    end
    tests++;
    if (req_a !== 32'h100) begin fails++; $display("FAIL rdw_addr: req addr %h, want 00000100", req_a); end
    tests++;
    if (pop_pc !== 32'h100 || pop_i !== mword(32'h100)) begin
      fails++; $display("FAIL rdw_instr: pc=%h instr=%h, want 00000100/%h", pop_pc, pop_i, mword(32'h100));
    end
  endtask

  task automatic test_redirect_rsp();
    bit got = 0;
    do_reset(1);
    imem_req_ready = 1; instr_ready = 0;
    #1;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (imem_rsp_valid !== 1'b1 || instr_valid !== 1'b1) begin
      fails++; $display("FAIL rdr_setup: rsp_valid=%b instr_valid=%b, want 1/1", imem_rsp_valid, instr_valid);
    end
    redirect_valid = 1; redirect_pc = 32'h203; #1;
    tests++;
    if (instr_valid !== 1'b0) begin fails++; $display("FAIL rdr_gate: instr_valid=%b, want 0", instr_valid); end
    @(negedge clk); redirect_valid = 0; #1;
    tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL rdr_next: req_valid=%b addr=%h instr_valid=%b, want 1/00000200/0",
                        imem_req_valid, imem_req_addr, instr_valid);
    end
    instr_ready = 1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk); #1;
      if (instr_valid) begin
        got = 1;
        tests++;
        if (instr_pc !== 32'h200 || instr !== mword(32'h200)) begin
          fails++; $display("FAIL rdr_first: pc=%h instr=%h, want 00000200/%h", instr_pc, instr, mword(32'h200));
        end
      end
    end
    tests++;
    if (!got) begin fails++; $display("FAIL rdr_timeout: no instruction after redirect"); end
  endtask

  task automatic test_wrap();
    do_reset(1);
    w_ready = 1; #1;
    tests++;
    if (w_req_valid !== 1'b1 || w_req_addr !== 32'hFFFF_FFFC) begin
      fails++; $display("FAIL wrap_first: valid=%b addr=%h, want 1/fffffffc", w_req_valid, w_req_addr);
    end
    @(negedge clk); w_ready = 0; w_rsp_valid = 1; w_rsp_data = 32'hDEAD_BEEF; #1;
    @(negedge clk); w_rsp_valid = 0; w_ready = 1; #1;
    tests++;
    if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0) begin
      fails++; $display("FAIL wrap_second: valid=%b addr=%h, want 1/00000000", w_req_valid, w_req_addr);
    end
    tests++;
    if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC || w_instr !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL wrap_instr: valid=%b pc=%h instr=%h, want 1/fffffffc/deadbeef",
                        w_instr_valid, w_instr_pc, w_instr);
    end
    w_ready = 0;
  endtask

  task automatic test_reset_mid();
    bit found = 0, got = 0;
    do_reset(1);
    imem_req_ready = 1; instr_ready = 1;
    for (int c = 0; c < 30 && !found; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h8) begin lat = 3; found = 1; end
    end
    tests++;
    if (!found) begin fails++; $display("FAIL rst_setup: request for 0x8 not seen"); end
    @(negedge clk); rst = 1; imem_req_ready = 0; #1;
    lat = 1;
    tests++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      fails++; $display("FAIL rst_outputs: req_valid=%b instr_valid=%b instr=%h pc=%h, want all 0",
                        imem_req_valid, instr_valid, instr, instr_pc);
    end
    @(negedge clk); rst = 0; #1;
    @(negedge clk); #1;
    tests++;
    if (imem_rsp_valid !== 1'b1 || instr_valid !== 1'b0) begin
      fails++; $display("FAIL rst_stale: rsp_valid=%b instr_valid=%b, want 1/0", imem_rsp_valid, instr_valid);
    end
    @(negedge clk); imem_req_ready = 1; #1;
    tests++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      fails++; $display("FAIL rst_restart: instr_valid=%b req_valid=%b addr=%h, want 0/1/00000000",
                        instr_valid, imem_req_valid, imem_req_addr);
    end
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk); #1;
      if (instr_valid) begin
        got = 1;
        tests++;
        if (instr_pc !== 32'h0 || instr !== mword(32'h0)) begin
          fails++; $display("FAIL rst_first: pc=%h instr=%h, want 00000000/%h", instr_pc, instr, mword(32'h0));
        end
      end
    end
    tests++;
    if (!got) begin fails++; $display("FAIL rst_timeout: no instruction after reset"); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    int npop = 0;
    do_reset(1);
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge clk);
      lat            = int'($urandom_range(1, 3));
      imem_req_ready = ($urandom_range(0, 9) < 7);
      instr_ready    = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      #1;
      if (redirect_valid) begin
        tests++;
        if (instr_valid !== 1'b0) begin
          fails++; $display("FAIL rand_redirect_gate: cycle %0d instr_valid=%b, want 0", c, instr_valid);
        end
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (instr_valid && instr_ready) begin
        tests++;
        if (instr_pc !== exp_pc || instr !== mword(exp_pc)) begin
          fails++; $display("FAIL rand_stream: cycle %0d pc=%h instr=%h, want pc=%h instr=%h",
                            c, instr_pc, instr, exp_pc, mword(exp_pc));
        end
        exp_pc = exp_pc + 32'h4;
        npop++;
      end
    end
    redirect_valid = 0; instr_ready = 0;
    tests++;
    if (npop < 20) begin fails++; $display("FAIL rand_progress: %0d instructions delivered, want >= 20", npop); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
